// File: rtl/hamming_code_pkg.sv
// Shared constants and FSM state type for the Hamming(15,11) transmit path.
package hamming_code_pkg;

  localparam int MSG_W      = 11;
  localparam int CW_W       = 15;
  localparam int FRAME_BITS = 17;
  localparam int N_PARITY   = 4;

  // Hamming positions (1-based) that carry parity rather than data.
  localparam int PARITY_POS [N_PARITY] = '{1, 2, 4, 8};

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ENCODE,
    ST_START,
    ST_DATA,
    ST_STOP
  } tx_state_e;

endpackage

// File: rtl/hamming_code_encoder.sv
// Pure combinational Hamming(15,11) even-parity encoder.
// Codeword bit i holds Hamming position i+1; parity sits at positions 1, 2, 4, 8.
module hamming_code_encoder
  import hamming_code_pkg::*;
(
  input  logic [MSG_W-1:0] data_i,
  output logic [CW_W-1:0]  codeword_o
);

  logic [CW_W-1:0] placed;

  // Data bits scattered over the non-power-of-two positions, parity slots zero.
  assign placed = {data_i[10:4], 1'b0, data_i[3:1], 1'b0, data_i[0], 2'b00};

  always_comb begin
    codeword_o = placed;
    for (int p = 0; p < N_PARITY; p++) begin
      for (int pos = 1; pos <= CW_W; pos++) begin
        if (((pos & PARITY_POS[p]) != 0) && (pos != PARITY_POS[p])) begin
          codeword_o[PARITY_POS[p]-1] = codeword_o[PARITY_POS[p]-1] ^ placed[pos-1];
        end
      end
    end
  end

endmodule

// File: rtl/hamming_code_encoder_tx.sv
// Hamming(15,11) encoder plus UART-style serialiser: start 0, codeword LSB first, stop 1.
// Handshake: a message is taken on any rising edge where msg_valid_en && msg_ready_en.
module hamming_code_encoder_tx
  import hamming_code_pkg::*;
#(
  parameter int CLKS_PER_BIT = 1
) (
  input  logic             clk_en,
  input  logic             rst_en,
  input  logic [MSG_W-1:0] msg_in_en,
  input  logic             msg_valid_en,
  output logic             msg_ready_en,
  output logic             msg_out_en,
  output logic             tx_done_en,
  output tx_state_e        dbg_state_en
);

  localparam int                BAUD_W    = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [3:0]        LAST_BIT  = 4'(CW_W - 1);

  tx_state_e         state_q, state_d;
  logic [BAUD_W-1:0] baud_q, baud_d;
  logic [3:0]        bit_q, bit_d;
  logic [MSG_W-1:0]  msg_q, msg_d;
  logic [CW_W-1:0]   cw_q, cw_d;
  logic              line_q, line_d;

  logic [CW_W-1:0]   cw_enc;
  logic              baud_last;
  logic [3:0]        bit_next;

  hamming_code_encoder u_encoder (
    .data_i     (msg_q),
    .codeword_o (cw_enc)
  );

  assign baud_last = (baud_q == BAUD_LAST);
  assign bit_next  = bit_q + 4'd1;

  always_ff @(posedge clk_en) begin
    if (rst_en) begin
      state_q <= ST_IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      msg_q   <= '0;
      cw_q    <= '0;
      line_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      msg_q   <= msg_d;
      cw_q    <= cw_d;
      line_q  <= line_d;
    end
  end

  // line_d is the level for the state being entered, so the pin changes on the same edge as the FSM.
  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    msg_d   = msg_q;
    cw_d    = cw_q;
    line_d  = line_q;
    unique case (state_q)
      ST_IDLE: begin
        line_d = 1'b1;
        if (msg_valid_en) begin
          msg_d   = msg_in_en;
          state_d = ST_ENCODE;
        end
      end
      ST_ENCODE: begin
        cw_d    = cw_enc;
        baud_d  = '0;
        bit_d   = '0;
        line_d  = 1'b0;
        state_d = ST_START;
      end
      ST_START: begin
        if (baud_last) begin
          baud_d  = '0;
          bit_d   = '0;
          line_d  = cw_q[0];
          state_d = ST_DATA;
        end else begin
          baud_d = baud_q + BAUD_W'(1);
        end
      end
      ST_DATA: begin
        if (baud_last) begin
          baud_d = '0;
          if (bit_q == LAST_BIT) begin
            line_d  = 1'b1;
            state_d = ST_STOP;
          end else begin
            bit_d  = bit_next;
            line_d = cw_q[bit_next];
          end
        end else begin
          baud_d = baud_q + BAUD_W'(1);
        end
      end
      ST_STOP: begin
        if (baud_last) begin
          baud_d  = '0;
          line_d  = 1'b1;
          state_d = ST_IDLE;
        end else begin
          baud_d = baud_q + BAUD_W'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
        line_d  = 1'b1;
      end
    endcase
  end

  assign msg_ready_en = (state_q == ST_IDLE);
  assign tx_done_en   = (state_q == ST_STOP) && baud_last;
  assign msg_out_en   = line_q;
  assign dbg_state_en = state_q;

endmodule
